// File: rtl/vx_dram_sched.sv
// DRAM request scheduler: round-robin arbiter from NUM_REQS sources into one
// registered DRAM request port, with per-source read credit limiting.
// Ports: clk/reset; req_*_in per-source requests (flattened) with req_ready_in
// grant; req_*_out registered DRAM request with req_ready_out backpressure;
// rsp_*_in DRAM response routed by tag low bits to rsp_*_out per source;
// pending_any flags any outstanding read.
module vx_dram_sched #(
   parameter int NUM_REQS     = 2,
   parameter int DATA_WIDTH   = 512,
   parameter int ADDR_WIDTH   = 26,
   parameter int TAG_IN_WIDTH = 8,
   parameter int MAX_PENDING  = 4,
   localparam int SEL_BITS      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
   localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS,
   localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQS-1:0]              req_valid_in,
   input  logic [NUM_REQS-1:0]              req_rw_in,
   input  logic [NUM_REQS*BE_WIDTH-1:0]     req_byteen_in,
   input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
   input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
   input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
   output logic [NUM_REQS-1:0]              req_ready_in,
   output logic                             req_valid_out,
   output logic                             req_rw_out,
   output logic [BE_WIDTH-1:0]              req_byteen_out,
   output logic [ADDR_WIDTH-1:0]            req_addr_out,
   output logic [DATA_WIDTH-1:0]            req_data_out,
   output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
   input  logic                             req_ready_out,
   input  logic                             rsp_valid_in,
   input  logic [DATA_WIDTH-1:0]            rsp_data_in,
   input  logic [TAG_OUT_WIDTH-1:0]         rsp_tag_in,
   output logic                             rsp_ready_in,
   output logic [NUM_REQS-1:0]              rsp_valid_out,
   output logic [DATA_WIDTH-1:0]            rsp_data_out,
   output logic [TAG_IN_WIDTH-1:0]          rsp_tag_out,
   input  logic [NUM_REQS-1:0]              rsp_ready_out,
   output logic                             pending_any
);

   localparam int CNT_W = $clog2(MAX_PENDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

   logic                     stage_free;
   logic [NUM_REQS-1:0]      eligible;
   logic                     grant_valid;
   logic [SEL_BITS-1:0]      grant_idx;
   int                       gsel;

   logic [SEL_BITS-1:0]      rr_ptr_q, rr_ptr_d;
   logic                     valid_q, valid_d;
   logic                     rw_q, rw_d;
   logic [BE_WIDTH-1:0]      byteen_q, byteen_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    data_q, data_d;
   logic [TAG_OUT_WIDTH-1:0] tag_q, tag_d;

   logic [CNT_W-1:0]         pending_q [NUM_REQS];
   logic [CNT_W-1:0]         pending_d [NUM_REQS];
   logic                     pending_any_q, pending_any_d;
   logic [NUM_REQS-1:0]      rd_inc;
   logic [NUM_REQS-1:0]      rsp_dec;

   logic [SEL_BITS-1:0]      rsp_sel;
   logic                     rsp_sel_ok;
   logic                     rsp_fire;

   assign stage_free = !valid_q || req_ready_out;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         eligible[i] = req_valid_in[i]
                    && (req_rw_in[i] || (pending_q[i] < CNT_MAX));
      end
   end

   // Scan from the farthest offset down so the source closest to rr_ptr
   // is the last to overwrite, i.e. it wins.
   always_comb begin
      int idx;
      idx         = 0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      if (stage_free && !reset) begin
         for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQS;
            if (eligible[idx]) begin
               grant_valid = 1'b1;
               grant_idx   = SEL_BITS'(idx);
            end
         end
      end
   end

   assign gsel = int'(grant_idx);

   always_comb begin
      req_ready_in = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         req_ready_in[i] = grant_valid && (grant_idx == SEL_BITS'(i));
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_valid) begin
         rr_ptr_d = SEL_BITS'((gsel + 1) % NUM_REQS);
      end
   end

   always_comb begin
      valid_d  = valid_q;
      rw_d     = rw_q;
      byteen_d = byteen_q;
      addr_d   = addr_q;
      data_d   = data_q;
      tag_d    = tag_q;
      if (grant_valid) begin
         valid_d  = 1'b1;
         rw_d     = req_rw_in[grant_idx];
         byteen_d = req_byteen_in[gsel*BE_WIDTH +: BE_WIDTH];
         addr_d   = req_addr_in[gsel*ADDR_WIDTH +: ADDR_WIDTH];
         data_d   = req_data_in[gsel*DATA_WIDTH +: DATA_WIDTH];
         tag_d    = {req_tag_in[gsel*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
      end else if (req_ready_out) begin
         valid_d  = 1'b0;
      end
   end

   assign rsp_sel    = rsp_tag_in[SEL_BITS-1:0];
   assign rsp_sel_ok = (int'(rsp_sel) < NUM_REQS);
   // An out-of-range tag is accepted and dropped so the DRAM side never
   // locks up behind it.
   assign rsp_ready_in = rsp_sel_ok ? rsp_ready_out[rsp_sel] : 1'b1;
   assign rsp_fire     = rsp_valid_in && rsp_ready_in && rsp_sel_ok;
   assign rsp_data_out = rsp_data_in;
   assign rsp_tag_out  = rsp_tag_in[TAG_OUT_WIDTH-1:SEL_BITS];

   always_comb begin
      rsp_valid_out = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         rsp_valid_out[i] = rsp_valid_in && (int'(rsp_sel) == i);
      end
   end

   always_comb begin
      rd_inc  = '0;
      rsp_dec = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         rd_inc[i]  = req_ready_in[i] && !req_rw_in[i];
         rsp_dec[i] = rsp_fire && (rsp_sel == SEL_BITS'(i));
      end
   end

   // A grant and a response for the same source cancel out; a decrement
   // on an empty counter is absorbed.
   always_comb begin
      pending_any_d = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         pending_d[i] = pending_q[i];
         if (rd_inc[i] && !rsp_dec[i]) begin
            pending_d[i] = pending_q[i] + 1'b1;
         end else if (rsp_dec[i] && !rd_inc[i] && (pending_q[i] != '0)) begin
            pending_d[i] = pending_q[i] - 1'b1;
         end
         pending_any_d = pending_any_d || (pending_d[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q       <= 1'b0;
         rw_q          <= 1'b0;
         rr_ptr_q      <= '0;
         pending_any_q <= 1'b0;
         for (int i = 0; i < NUM_REQS; i++) begin
            pending_q[i] <= '0;
         end
      end else begin
         valid_q       <= valid_d;
         rw_q          <= rw_d;
         rr_ptr_q      <= rr_ptr_d;
         pending_any_q <= pending_any_d;
         for (int i = 0; i < NUM_REQS; i++) begin
            pending_q[i] <= pending_d[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      byteen_q <= byteen_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
   end

   assign req_valid_out  = valid_q;
   assign req_rw_out     = rw_q;
   assign req_byteen_out = byteen_q;
   assign req_addr_out   = addr_q;
   assign req_data_out   = data_q;
   assign req_tag_out    = tag_q;
   assign pending_any    = pending_any_q;

   always_ff @(posedge clk) begin
      if (!reset && rsp_valid_in) begin
         assert (rsp_sel_ok)
            else $error("vx_dram_sched: response sel %0d out of range", rsp_sel);
         if (rsp_fire) begin
            assert (pending_q[rsp_sel] != '0)
               else $error("vx_dram_sched: response to idle source %0d", rsp_sel);
         end
      end
   end

endmodule

// File: tb/tb_vx_dram_sched.sv
// Testbench for vx_dram_sched: directed vectors, scoreboard queues for DRAM
// requests and routed responses, checked by a negedge monitor.
module tb_vx_dram_sched;

   localparam int NR  = 2;
   localparam int DW  = 32;
   localparam int AW  = 26;
   localparam int TW  = 8;
   localparam int BW  = DW / 8;
   localparam int TOW = TW + 1;

   typedef struct packed {
      logic           rw;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  data;
      logic [BW-1:0]  be;
      logic [TOW-1:0] tag;
   } req_t;

   typedef struct packed {
      logic [NR-1:0] vec;
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } rsp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     vld, rw;
   logic [NR*BW-1:0]  be;
   logic [NR*AW-1:0]  addr;
   logic [NR*DW-1:0]  data;
   logic [NR*TW-1:0]  tag;
   logic [NR-1:0]     rdy_in;
   logic              o_valid, o_rw;
   logic [BW-1:0]     o_be;
   logic [AW-1:0]     o_addr;
   logic [DW-1:0]     o_data;
   logic [TOW-1:0]    o_tag;
   logic              o_ready;
   logic              r_valid;
   logic [DW-1:0]     r_data;
   logic [TOW-1:0]    r_tag;
   logic              r_ready;
   logic [NR-1:0]     s_valid;
   logic [DW-1:0]     s_data;
   logic [TW-1:0]     s_tag;
   logic [NR-1:0]     s_ready;
   logic              p_any;

   int   n_chk  = 0;
   int   n_fail = 0;
   req_t req_q[$];
   rsp_t rsp_q[$];
   req_t mon_req;
   rsp_t mon_rsp;

   vx_dram_sched #(
      .NUM_REQS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .TAG_IN_WIDTH(TW), .MAX_PENDING(4)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid_in(vld), .req_rw_in(rw), .req_byteen_in(be),
      .req_addr_in(addr), .req_data_in(data), .req_tag_in(tag),
      .req_ready_in(rdy_in),
      .req_valid_out(o_valid), .req_rw_out(o_rw), .req_byteen_out(o_be),
      .req_addr_out(o_addr), .req_data_out(o_data), .req_tag_out(o_tag),
      .req_ready_out(o_ready),
      .rsp_valid_in(r_valid), .rsp_data_in(r_data), .rsp_tag_in(r_tag),
      .rsp_ready_in(r_ready),
      .rsp_valid_out(s_valid), .rsp_data_out(s_data), .rsp_tag_out(s_tag),
      .rsp_ready_out(s_ready),
      .pending_any(p_any)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, required end of test");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int s, input logic r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] b,
                          input logic [TW-1:0] t);
      rw[s]             = r;
      addr[s*AW +: AW]  = a;
      data[s*DW +: DW]  = d;
      be[s*BW +: BW]    = b;
      tag[s*TW +: TW]   = t;
   endtask

   task automatic exp_req(input logic r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] b,
                          input logic [TOW-1:0] t);
      req_q.push_back('{rw: r, addr: a, data: d, be: b, tag: t});
   endtask

   task automatic send_rsp(input logic [TOW-1:0] t, input logic [DW-1:0] d,
                           input logic [NR-1:0] v, input logic [TW-1:0] et);
      r_valid = 1'b1;
      r_tag   = t;
      r_data  = d;
      rsp_q.push_back('{vec: v, tag: et, data: d});
   endtask

   always @(negedge clk) begin
      if (!reset && o_valid && o_ready) begin
         n_chk++;
         if (req_q.size() == 0) begin
            n_fail++;
            $display("FAIL req_unexpected: got addr %0h tag %0h, required none",
                     o_addr, o_tag);
         end else begin
            mon_req = req_q.pop_front();
            if ({o_rw, o_addr, o_data, o_be, o_tag} !== mon_req) begin
               n_fail++;
               $display("FAIL req_out: got rw %0b addr %0h data %0h be %0h tag %0h, required rw %0b addr %0h data %0h be %0h tag %0h",
                        o_rw, o_addr, o_data, o_be, o_tag, mon_req.rw,
                        mon_req.addr, mon_req.data, mon_req.be, mon_req.tag);
            end
         end
      end
      if (!reset && r_valid && r_ready) begin
         n_chk++;
         if (rsp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: got tag %0h, required none", s_tag);
         end else begin
            mon_rsp = rsp_q.pop_front();
            if ({s_valid, s_tag, s_data} !== mon_rsp) begin
               n_fail++;
               $display("FAIL rsp_out: got vec %0b tag %0h data %0h, required vec %0b tag %0h data %0h",
                        s_valid, s_tag, s_data, mon_rsp.vec, mon_rsp.tag,
                        mon_rsp.data);
            end
         end
      end
   end

   initial begin
      reset   = 1'b1;
      vld     = '0;
      rw      = '0;
      be      = '0;
      addr    = '0;
      data    = '0;
      tag     = '0;
      o_ready = 1'b1;
      r_valid = 1'b0;
      r_data  = '0;
      r_tag   = '0;
      s_ready = '1;
      cyc();
      vld = 2'b11;
      #1;
      chk("ready_in_in_reset", 64'(rdy_in), 64'h0);
      cyc();
      vld = 2'b00;
      reset = 1'b0;
      #1;
      chk("reset_valid_out", 64'(o_valid), 64'h0);
      chk("reset_pending_any", 64'(p_any), 64'h0);

      // alternating grants
      set_src(0, 1'b0, 26'h100, 32'hA0, 4'hF, 8'h11);
      set_src(1, 1'b0, 26'h200, 32'hB1, 4'h3, 8'h22);
      vld = 2'b11;
      for (int j = 0; j < 4; j++) begin
         #1;
         if (j % 2 == 0) begin
            chk("rr_ready_in", 64'(rdy_in), 64'h1);
            exp_req(1'b0, 26'h100, 32'hA0, 4'hF, 9'h022);
         end else begin
            chk("rr_ready_in", 64'(rdy_in), 64'h2);
            exp_req(1'b0, 26'h200, 32'hB1, 4'h3, 9'h045);
         end
         cyc();
      end
      vld = 2'b00;
      #1;
      chk("pending_any_set", 64'(p_any), 64'h1);

      // drain: two to source 0, then 0x0B stalled then accepted, then one more
      send_rsp(9'h022, 32'h1000, 2'b01, 8'h11);
      cyc();
      send_rsp(9'h022, 32'h1001, 2'b01, 8'h11);
      cyc();
      r_valid = 1'b1;
      r_tag   = 9'h00B;
      r_data  = 32'h1002;
      s_ready = 2'b01;
      #1;
      chk("rsp_route_vec", 64'(s_valid), 64'h2);
      chk("rsp_route_tag", 64'(s_tag), 64'h05);
      chk("rsp_ready_blocked", 64'(r_ready), 64'h0);
      cyc();
      s_ready = 2'b11;
      send_rsp(9'h00B, 32'h1002, 2'b10, 8'h05);
      cyc();
      send_rsp(9'h045, 32'h1003, 2'b10, 8'h22);
      cyc();
      r_valid = 1'b0;
      #1;
      chk("pending_any_clear", 64'(p_any), 64'h0);

      // credit limit on source 0
      set_src(0, 1'b0, 26'h300, 32'hC0, 4'h1, 8'h33);
      vld = 2'b01;
      for (int j = 0; j < 4; j++) begin
         #1;
         chk("credit_grant", 64'(rdy_in), 64'h1);
         exp_req(1'b0, 26'h300, 32'hC0, 4'h1, 9'h066);
         cyc();
      end
      set_src(1, 1'b0, 26'h400, 32'hD1, 4'h2, 8'h44);
      vld = 2'b11;
      #1;
      chk("credit_other_src", 64'(rdy_in), 64'h2);
      exp_req(1'b0, 26'h400, 32'hD1, 4'h2, 9'h089);
      cyc();
      vld = 2'b01;
      send_rsp(9'h066, 32'h2000, 2'b01, 8'h33);
      #1;
      chk("credit_stall", 64'(rdy_in), 64'h0);
      cyc();
      r_valid = 1'b0;
      #1;
      chk("credit_resume", 64'(rdy_in), 64'h1);
      exp_req(1'b0, 26'h300, 32'hC0, 4'h1, 9'h066);
      cyc();
      vld = 2'b00;
      cyc();

      // backpressure hold
      o_ready = 1'b0;
      set_src(1, 1'b1, 26'h500, 32'hDEAD, 4'hC, 8'h55);
      vld = 2'b10;
      #1;
      chk("bp_first_grant", 64'(rdy_in), 64'h2);
      exp_req(1'b1, 26'h500, 32'hDEAD, 4'hC, 9'h0AB);
      cyc();
      set_src(0, 1'b1, 26'h600, 32'hBEEF, 4'h5, 8'h66);
      vld = 2'b11;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk("bp_ready_in", 64'(rdy_in), 64'h0);
         chk("bp_hold", {o_valid, o_rw, o_addr, o_tag},
             {1'b1, 1'b1, 26'h500, 9'h0AB});
         cyc();
      end
      o_ready = 1'b1;
      #1;
      chk("bp_rr_kept", 64'(rdy_in), 64'h1);
      exp_req(1'b1, 26'h600, 32'hBEEF, 4'h5, 9'h0CC);
      cyc();
      vld = 2'b00;

      // drain source 0 (four reads outstanding)
      for (int j = 0; j < 4; j++) begin
         send_rsp(9'h0F0 + 9'(2 * j), 32'h3000 + 32'(j), 2'b01, 8'h78 + 8'(j));
         cyc();
      end
      r_valid = 1'b0;
      #1;
      chk("src1_still_pending", 64'(p_any), 64'h1);

      // grant + response to source 1 in the same cycle
      set_src(1, 1'b0, 26'h700, 32'hE1, 4'h8, 8'h77);
      vld = 2'b10;
      #1;
      chk("same_cyc_pre", 64'(rdy_in), 64'h2);
      exp_req(1'b0, 26'h700, 32'hE1, 4'h8, 9'h0EF);
      cyc();
      send_rsp(9'h001, 32'h4000, 2'b10, 8'h00);
      #1;
      chk("same_cyc_grant", 64'(rdy_in), 64'h2);
      exp_req(1'b0, 26'h700, 32'hE1, 4'h8, 9'h0EF);
      cyc();
      vld = 2'b00;
      send_rsp(9'h003, 32'h4001, 2'b10, 8'h01);
      cyc();
      #1;
      chk("same_cyc_left_one", 64'(p_any), 64'h1);
      send_rsp(9'h005, 32'h4002, 2'b10, 8'h02);
      cyc();
      r_valid = 1'b0;
      #1;
      chk("same_cyc_drained", 64'(p_any), 64'h0);

      // reset with a request held and three reads outstanding
      set_src(0, 1'b0, 26'h800, 32'hF0, 4'h9, 8'h88);
      vld = 2'b01;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk("pre_reset_grant", 64'(rdy_in), 64'h1);
         if (j < 2) exp_req(1'b0, 26'h800, 32'hF0, 4'h9, 9'h110);
         cyc();
      end
      vld = 2'b00;
      o_ready = 1'b0;
      #1;
      chk("pre_reset_state", {o_valid, p_any}, 2'b11);
      cyc();
      reset = 1'b1;
      set_src(1, 1'b0, 26'h900, 32'hF1, 4'h6, 8'h99);
      vld = 2'b11;
      #1;
      chk("reset_blocks_ready", 64'(rdy_in), 64'h0);
      cyc();
      reset = 1'b0;
      #1;
      chk("post_reset_state", {o_valid, p_any}, 2'b00);
      o_ready = 1'b1;
      #1;
      chk("post_reset_first", 64'(rdy_in), 64'h1);
      exp_req(1'b0, 26'h800, 32'hF0, 4'h9, 9'h110);
      cyc();
      vld = 2'b00;
      for (int j = 0; j < 20 && (req_q.size() != 0 || rsp_q.size() != 0); j++) begin
         cyc();
      end
      cyc();
      chk("req_queue_empty", 64'(req_q.size()), 64'h0);
      chk("rsp_queue_empty", 64'(rsp_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
